// File: rtl/command_sequencer.sv
// Command sequencer: replays a small program of 12-bit command words to a controller.
// Each slot is issued with a one-cycle syscall strobe, allowed SETTLE_CYCLES to settle,
// then the controller result y is checked. CAS commands (opcode 3'b111) that report
// failure in y[0] are reissued up to MAX_RETRY times before cas_fail is raised.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   load_en_i          program-slot write strobe (honoured only when idle)
//   load_addr_i        slot to write
//   load_data_i        command word {opcode, addr1, addr2, addr3}
//   prog_len_i         number of slots to run from slot 0 (clamped to DEPTH)
//   start_i            begin execution (honoured only when idle)
//   y_i                controller result; bit 0 is the CAS success flag
//   command_o          command presented to the controller
//   syscall_o          one-cycle issue strobe
//   busy_o             high whenever not idle
//   done_o             one-cycle program-complete pulse
//   cas_fail_o         sticky: a CAS ran out of retries
//   pc_o               slot currently executing
module command_sequencer #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MAX_RETRY     = 3,
  localparam int unsigned AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [11:0]   load_data_i,
  input  logic [AW:0]   prog_len_i,
  input  logic          start_i,
  input  logic [31:0]   y_i,
  output logic [11:0]   command_o,
  output logic          syscall_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          cas_fail_o,
  output logic [AW-1:0] pc_o
);

  localparam int unsigned RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] MaxRetry = RW'(MAX_RETRY);
  localparam logic [3:0]  SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [AW:0] DepthLen   = (AW+1)'(DEPTH);
  localparam logic [2:0]  CasOp      = 3'b111;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   last_q, last_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [3:0]      settle_q, settle_d;
  logic            cas_fail_q, cas_fail_d;
  logic [11:0]     command_q, command_d;

  // Program store has no reset so its contents survive rst_n.
  logic [11:0]     slot_q [DEPTH];

  logic            unused_y;
  assign unused_y = ^y_i[31:1];

  always_ff @(posedge clk) begin
    if (state_q == StIdle && load_en_i) begin
      slot_q[load_addr_i] <= load_data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    last_d     = last_q;
    retry_d    = retry_q;
    settle_d   = settle_q;
    cas_fail_d = cas_fail_q;
    command_d  = command_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          pc_d       = '0;
          retry_d    = '0;
          cas_fail_d = 1'b0;
          if (prog_len_i == '0) begin
            state_d = StDone;
          end else begin
            last_d    = (prog_len_i > DepthLen) ? AW'(DEPTH - 1) : AW'(prog_len_i - 1'b1);
            command_d = slot_q[0];
            state_d   = StIssue;
          end
        end
      end
      StIssue: begin
        settle_d = '0;
        state_d  = StWait;
      end
      StWait: begin
        if (settle_q == SettleLast) begin
          state_d = StCheck;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StCheck: begin
        if (command_q[11:9] == CasOp && !y_i[0] && retry_q < MaxRetry) begin
          retry_d = retry_q + 1'b1;
          state_d = StIssue;
        end else begin
          if (command_q[11:9] == CasOp && !y_i[0]) begin
            cas_fail_d = 1'b1;
          end
          retry_d = '0;
          if (pc_q == last_q) begin
            state_d = StDone;
          end else begin
            pc_d      = pc_q + 1'b1;
            command_d = slot_q[pc_d];
            state_d   = StIssue;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      last_q     <= '0;
      retry_q    <= '0;
      settle_q   <= '0;
      cas_fail_q <= 1'b0;
      command_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      last_q     <= last_d;
      retry_q    <= retry_d;
      settle_q   <= settle_d;
      cas_fail_q <= cas_fail_d;
      command_q  <= command_d;
    end
  end

  assign command_o  = command_q;
  assign syscall_o  = (state_q == StIssue);
  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);
  assign cas_fail_o = cas_fail_q;
  assign pc_o       = pc_q;

endmodule

// File: tb/tb_command_sequencer.sv
// Directed bench for command_sequencer (DEPTH=16, SETTLE_CYCLES=2, MAX_RETRY=3).
module tb_command_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [11:0] load_data = '0;
  logic [4:0]  prog_len = '0;
  logic        start = 1'b0;
  logic [31:0] y = '0;
  logic [11:0] command;
  logic        syscall, busy, done, cas_fail;
  logic [3:0]  pc;

  int n_run = 0;
  int n_fail = 0;

  // Observations gathered by run_prog
  int          n_sys, n_done, pc_max, done_c, intf_pc;
  logic [11:0] cmds[$];
  int          tcyc[$];
  bit          timed_out, done_stuck, intf_busy;
  bit          y_mode = 1'b0;
  logic        y_const = 1'b1;

  command_sequencer #(
    .DEPTH(16), .SETTLE_CYCLES(2), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_en_i(load_en), .load_addr_i(load_addr),
    .load_data_i(load_data), .prog_len_i(prog_len), .start_i(start), .y_i(y),
    .command_o(command), .syscall_o(syscall), .busy_o(busy), .done_o(done),
    .cas_fail_o(cas_fail), .pc_o(pc)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [11:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick;
    load_en = 1'b0;
  endtask

  // mode 0: plain run; 1: interfere during WAIT of slot 1; 2: assert reset there and return.
  task automatic run_prog(input logic [4:0] len, input int mode);
    int m;
    m = mode;
    n_sys = 0; n_done = 0; pc_max = 0; done_c = -1; intf_pc = -1; intf_busy = 1'b0;
    cmds.delete(); tcyc.delete(); timed_out = 1'b0; done_stuck = 1'b0;
    prog_len = len; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (syscall) begin
        cmds.push_back(command); tcyc.push_back(c); n_sys++;
      end
      if (busy && int'(pc) > pc_max) pc_max = int'(pc);
      if (m != 0 && syscall && pc == 4'd1) begin
        y = y_mode ? {31'b0, n_sys >= 2} : {31'b0, y_const};
        tick;
        if (m == 2) begin
          rst_n = 1'b0;
          return;
        end
        load_en = 1'b1; load_addr = 4'd1; load_data = 12'hFFF; start = 1'b1;
        tick;
        load_en = 1'b0; start = 1'b0;
        intf_pc = int'(pc); intf_busy = busy;
        m = 0;
      end
      if (done) begin
        n_done++; done_c = c;
        tick;
        if (done) done_stuck = 1'b1;
        return;
      end
      y = y_mode ? {31'b0, n_sys >= 2} : {31'b0, y_const};
      tick;
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_run++; if (syscall !== 1'b0) begin n_fail++; $display("FAIL reset_syscall got %b want 0", syscall); end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_run++; if (cas_fail !== 1'b0) begin n_fail++; $display("FAIL reset_cas_fail got %b want 0", cas_fail); end
    n_run++; if (pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc); end
    n_run++; if (command !== 12'h000) begin n_fail++; $display("FAIL reset_command got %h want 000", command); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    load(4'd0, 12'h0C8); load(4'd1, 12'h251); load(4'd2, 12'h4D3);
    y_mode = 1'b0; y_const = 1'b1;
    run_prog(5'd3, 0);
    n_run++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout got timeout want done"); end
    n_run++; if (n_sys != 3) begin n_fail++; $display("FAIL basic_issues got %0d want 3", n_sys); end
    n_run++; if (cmds[0] !== 12'h0C8) begin n_fail++; $display("FAIL basic_cmd0 got %h want 0C8", cmds[0]); end
    n_run++; if (cmds[1] !== 12'h251) begin n_fail++; $display("FAIL basic_cmd1 got %h want 251", cmds[1]); end
    n_run++; if (cmds[2] !== 12'h4D3) begin n_fail++; $display("FAIL basic_cmd2 got %h want 4D3", cmds[2]); end
    n_run++; if (tcyc[1] - tcyc[0] != 4) begin n_fail++; $display("FAIL basic_gap01 got %0d want 4", tcyc[1] - tcyc[0]); end
    n_run++; if (tcyc[2] - tcyc[1] != 4) begin n_fail++; $display("FAIL basic_gap12 got %0d want 4", tcyc[2] - tcyc[1]); end
    n_run++; if (n_done != 1 || done_stuck) begin n_fail++; $display("FAIL basic_done got %0d stuck=%b want 1 pulse", n_done, done_stuck); end
    n_run++; if (cas_fail !== 1'b0) begin n_fail++; $display("FAIL basic_cas_fail got %b want 0", cas_fail); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_cas_retry;
    load(4'd0, 12'hE4A);
    y_mode = 1'b1;
    run_prog(5'd1, 0);
    y_mode = 1'b0;
    n_run++; if (n_sys != 2) begin n_fail++; $display("FAIL casok_issues got %0d want 2", n_sys); end
    n_run++; if (cmds[0] !== 12'hE4A || cmds[1] !== 12'hE4A) begin
      n_fail++; $display("FAIL casok_cmds got %h,%h want E4A,E4A", cmds[0], cmds[1]);
    end
    n_run++; if (n_done != 1) begin n_fail++; $display("FAIL casok_done got %0d want 1", n_done); end
    n_run++; if (cas_fail !== 1'b0) begin n_fail++; $display("FAIL casok_cas_fail got %b want 0", cas_fail); end
  endtask

  task automatic test_cas_exhaust;
    int k;
    y_mode = 1'b0; y_const = 1'b0;
    run_prog(5'd1, 0);
    n_run++; if (n_sys != 4) begin n_fail++; $display("FAIL casx_issues got %0d want 4", n_sys); end
    n_run++; if (n_done != 1) begin n_fail++; $display("FAIL casx_done got %0d want 1", n_done); end
    repeat (3) tick;
    n_run++; if (cas_fail !== 1'b1) begin n_fail++; $display("FAIL casx_sticky got %b want 1", cas_fail); end
    y_const = 1'b1; y = 32'd1;
    prog_len = 5'd1; start = 1'b1;
    tick;
    start = 1'b0;
    n_run++; if (cas_fail !== 1'b0) begin n_fail++; $display("FAIL casx_clear got %b want 0", cas_fail); end
    k = 0;
    while (busy && k < 100) begin tick; k++; end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL casx_finish got busy=%b want 0", busy); end
  endtask

  task automatic test_len_zero;
    run_prog(5'd0, 0);
    n_run++; if (done_c != 0) begin n_fail++; $display("FAIL len0_done_cycle got %0d want 0", done_c); end
    n_run++; if (n_sys != 0) begin n_fail++; $display("FAIL len0_issues got %0d want 0", n_sys); end
  endtask

  task automatic test_len_overflow;
    for (int i = 0; i < 16; i++) load(4'(i), 12'h100 + 12'(i));
    y_const = 1'b1;
    run_prog(5'd20, 0);
    n_run++; if (n_sys != 16) begin n_fail++; $display("FAIL len20_issues got %0d want 16", n_sys); end
    n_run++; if (pc_max != 15) begin n_fail++; $display("FAIL len20_pc_max got %0d want 15", pc_max); end
    n_run++; if (cmds[15] !== 12'h10F) begin n_fail++; $display("FAIL len20_last_cmd got %h want 10F", cmds[15]); end
    n_run++; if (n_done != 1) begin n_fail++; $display("FAIL len20_done got %0d want 1", n_done); end
  endtask

  task automatic test_interference;
    load(4'd0, 12'h0C8); load(4'd1, 12'h251); load(4'd2, 12'h4D3);
    y_const = 1'b1;
    run_prog(5'd3, 1);
    n_run++; if (intf_pc != 1 || !intf_busy) begin
      n_fail++; $display("FAIL intf_start_ignored got pc=%0d busy=%b want pc=1 busy=1", intf_pc, intf_busy);
    end
    n_run++; if (n_sys != 3) begin n_fail++; $display("FAIL intf_issues got %0d want 3", n_sys); end
    n_run++; if (n_done != 1) begin n_fail++; $display("FAIL intf_done got %0d want 1", n_done); end
    run_prog(5'd3, 0);
    n_run++; if (cmds[1] !== 12'h251) begin n_fail++; $display("FAIL intf_slot_kept got %h want 251", cmds[1]); end
  endtask

  task automatic test_reset_abort;
    int bad;
    int k;
    y_const = 1'b1;
    run_prog(5'd3, 2);
    #1;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_run++; if (pc !== 4'd0) begin n_fail++; $display("FAIL abort_pc got %h want 0", pc); end
    n_run++; if (n_sys != 2) begin n_fail++; $display("FAIL abort_issues got %0d want 2", n_sys); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (syscall || done) bad++;
      tick;
    end
    n_run++; if (bad != 0) begin n_fail++; $display("FAIL abort_quiet got %0d active cycles want 0", bad); end
    rst_n = 1'b1;
    prog_len = 5'd3; start = 1'b1;
    tick;
    start = 1'b0;
    n_run++; if (syscall !== 1'b1 || command !== 12'h0C8) begin
      n_fail++; $display("FAIL abort_restart got syscall=%b cmd=%h want 1,0C8", syscall, command);
    end
    k = 0;
    while (busy && k < 100) begin tick; k++; end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_finish got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_cas_retry;
    test_cas_exhaust;
    test_len_zero;
    test_len_overflow;
    test_interference;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
